// File: rtl/mux_skid.sv
// -----------------------------------------------------------------------------
// mux_skid
//
// N:1 operand-select stage with a registered output and a two-entry skid
// buffer. One channel is picked from a flattened input bus by a binary select.
// The selected word lands in the main output register. If the downstream stage
// stalls while a second beat arrives, that beat is parked in the skid
// register. This keeps upstream running without a bubble.
//
// Optional feature macro: MUX_SKID_SEL_ERR_EN
//   When defined, a sticky sel_err output flags any accepted beat whose select
//   was out of range. Only reset clears it.
//
// Parameters:
//   WIDTH  data width of each channel and of the output
//   N      number of input channels (2..16)
//   SELW   width of sel, $clog2(N)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_data    N*WIDTH flattened channels, channel i at [i*WIDTH +: WIDTH]
//   sel        channel index, sampled with in_data on acceptance
//   in_valid   upstream offers a beat
//   in_ready   stage can accept (registered, low only while the skid is full)
//   flush      discard every buffered beat
//   out_data   selected word held in the main register
//   out_valid  out_data is valid
//   out_ready  downstream accepts
//   sel_err    sticky out-of-range select flag (MUX_SKID_SEL_ERR_EN only)
// -----------------------------------------------------------------------------
module mux_skid #(
   parameter int  WIDTH = 32,
   parameter int  N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]    sel,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready
`ifdef MUX_SKID_SEL_ERR_EN
   ,
   output logic               sel_err
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [WIDTH-1:0]   skid_data_q, skid_data_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;

   logic [WIDTH-1:0]   sel_word;
   logic               accept;
   logic               drain;

   // Out-of-range selects produce the all-zero word.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i) sel_word = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      skid_data_d = skid_data_q;

      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               out_data_d = sel_word;
               state_d    = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && drain) begin
               out_data_d = sel_word;
            end else if (accept) begin
               skid_data_d = sel_word;
               state_d     = S_FULL;
            end else if (drain) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            // in_ready is low here, so only a drain can move the state.
            if (drain) begin
               out_data_d = skid_data_q;
               state_d    = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase

      // Flush overrides everything. A drain in the same cycle has already
      // been consumed downstream. A beat accepted in that cycle is lost.
      if (flush) state_d = S_EMPTY;

      // The flags are registered copies of the next state. That keeps
      // in_ready and out_valid free of any combinational input path.
      out_valid_d = (state_d != S_EMPTY);
      in_ready_d  = (state_d != S_FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         out_data_q  <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         out_data_q  <= out_data_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef MUX_SKID_SEL_ERR_EN
   logic sel_oob;
   logic sel_err_q, sel_err_d;

   assign sel_oob = (int'(sel) >= N);

   // Sticky: a flush does not clear it.
   always_comb begin
      sel_err_d = sel_err_q | (accept & sel_oob);
   end

   always_ff @(posedge clk) begin
      if (reset) sel_err_q <= 1'b0;
      else       sel_err_q <= sel_err_d;
   end

   assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_skid.sv
// -----------------------------------------------------------------------------
// tb_mux_skid
//
// Three instances of mux_skid share one clock:
//   u_a  WIDTH=32, N=4  directed vector table
//                       (streaming, backpressure, flush, mid-stream reset)
//   u_b  WIDTH=32, N=3  out-of-range select, including sel_err when enabled
//   u_c  WIDTH=16, N=8  random valid/ready/flush traffic checked against a
//                       queue model
// -----------------------------------------------------------------------------
module tb_mux_skid;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- instance A: N=4, WIDTH=32 ----------------
   logic         a_rst = 1'b0, a_flush = 1'b0, a_iv = 1'b0, a_ordy = 1'b0;
   logic [1:0]   a_sel = '0;
   logic [127:0] a_din = '0;
   logic [31:0]  a_od;
   logic         a_ov, a_ir;
`ifdef MUX_SKID_SEL_ERR_EN
   logic         a_err;
`endif

   mux_skid #(.WIDTH(32), .N(4)) u_a (
      .clk(clk), .reset(a_rst), .in_data(a_din), .sel(a_sel),
      .in_valid(a_iv), .in_ready(a_ir), .flush(a_flush),
      .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy)
`ifdef MUX_SKID_SEL_ERR_EN
      , .sel_err(a_err)
`endif
   );

   // ---------------- instance B: N=3, WIDTH=32 ----------------
   logic         b_rst = 1'b0, b_flush = 1'b0, b_iv = 1'b0, b_ordy = 1'b0;
   logic [1:0]   b_sel = '0;
   logic [95:0]  b_din = {32'h3, 32'h2, 32'h1};
   logic [31:0]  b_od;
   logic         b_ov, b_ir;
`ifdef MUX_SKID_SEL_ERR_EN
   logic         b_err;
`endif

   mux_skid #(.WIDTH(32), .N(3)) u_b (
      .clk(clk), .reset(b_rst), .in_data(b_din), .sel(b_sel),
      .in_valid(b_iv), .in_ready(b_ir), .flush(b_flush),
      .out_data(b_od), .out_valid(b_ov), .out_ready(b_ordy)
`ifdef MUX_SKID_SEL_ERR_EN
      , .sel_err(b_err)
`endif
   );

   // ---------------- instance C: N=8, WIDTH=16 ----------------
   logic         c_rst = 1'b0, c_flush = 1'b0, c_iv = 1'b0, c_ordy = 1'b0;
   logic [2:0]   c_sel = '0;
   logic [127:0] c_din = '0;
   logic [15:0]  c_od;
   logic         c_ov, c_ir;
`ifdef MUX_SKID_SEL_ERR_EN
   logic         c_err;
`endif

   mux_skid #(.WIDTH(16), .N(8)) u_c (
      .clk(clk), .reset(c_rst), .in_data(c_din), .sel(c_sel),
      .in_valid(c_iv), .in_ready(c_ir), .flush(c_flush),
      .out_data(c_od), .out_valid(c_ov), .out_ready(c_ordy)
`ifdef MUX_SKID_SEL_ERR_EN
      , .sel_err(c_err)
`endif
   );

   // ---------------- directed vector table for instance A ----------------
   // Each record holds the inputs driven before one rising edge. It also
   // holds the outputs required just after that edge.
   typedef struct {
      logic         rst, flush, iv, ordy;
      logic [1:0]   sel;
      logic [127:0] din;
      logic         eov, eir, chk_od;
      logic [31:0]  eod;
   } vec_t;

   vec_t vq[$];

   function automatic logic [127:0] rep(input logic [31:0] v);
      return {v, v, v, v};
   endfunction

   task automatic add(input logic rst, input logic flush, input logic iv,
                      input logic ordy, input logic [1:0] sel, input logic [127:0] din,
                      input logic eov, input logic eir, input logic chk_od,
                      input logic [31:0] eod);
      vec_t v;
      v.rst = rst; v.flush = flush; v.iv = iv; v.ordy = ordy; v.sel = sel;
      v.din = din; v.eov = eov; v.eir = eir; v.chk_od = chk_od; v.eod = eod;
      vq.push_back(v);
   endtask

   localparam logic [127:0] CH = {32'h44, 32'h33, 32'h22, 32'h11};

   // random-phase model state
   logic [15:0] mq[$];
   logic [15:0] word;
   logic        acc, last_acc;

   initial begin
      //   rst flush iv ordy sel din       eov eir chk eod
      add(1, 0, 0, 0, 0, CH,        0, 1, 1, 32'h0);  // reset state
      add(0, 0, 1, 1, 2, CH,        1, 1, 1, 32'h33); // stream
      add(0, 0, 1, 1, 0, CH,        1, 1, 1, 32'h11);
      add(0, 0, 1, 1, 3, CH,        1, 1, 1, 32'h44);
      add(0, 0, 0, 1, 0, CH,        0, 1, 0, 32'h0);
      add(0, 0, 1, 0, 0, rep(32'hA), 1, 1, 1, 32'hA); // backpressure
      add(0, 0, 1, 0, 0, rep(32'hB), 1, 0, 1, 32'hA);
      add(0, 0, 0, 0, 0, rep(32'hB), 1, 0, 1, 32'hA);
      add(0, 0, 0, 1, 0, rep(32'hB), 1, 1, 1, 32'hB);
      add(0, 0, 0, 1, 0, rep(32'hB), 0, 1, 0, 32'h0);
      add(0, 0, 1, 0, 0, rep(32'hC), 1, 1, 1, 32'hC); // flush in FULL + drain
      add(0, 0, 1, 0, 0, rep(32'hD), 1, 0, 1, 32'hC);
      add(0, 1, 0, 1, 0, rep(32'hD), 0, 1, 0, 32'h0);
      add(0, 0, 0, 1, 0, rep(32'hD), 0, 1, 0, 32'h0);
      add(0, 0, 1, 0, 0, rep(32'hE), 1, 1, 1, 32'hE); // reset in FULL
      add(0, 0, 1, 0, 0, rep(32'hF), 1, 0, 1, 32'hE);
      add(1, 0, 0, 0, 0, rep(32'hF), 0, 1, 1, 32'h0);
      add(0, 0, 1, 0, 0, rep(32'h5), 1, 1, 1, 32'h5);
      add(0, 0, 0, 1, 0, rep(32'h5), 0, 1, 0, 32'h0);
      add(0, 1, 1, 1, 0, rep(32'h7), 0, 1, 0, 32'h0); // accept during flush
      add(0, 0, 0, 1, 0, rep(32'h7), 0, 1, 0, 32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         a_rst = vq[i].rst; a_flush = vq[i].flush; a_iv = vq[i].iv;
         a_ordy = vq[i].ordy; a_sel = vq[i].sel; a_din = vq[i].din;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_out_valid", i), {31'b0, a_ov}, {31'b0, vq[i].eov});
         chk($sformatf("vec%0d_in_ready", i), {31'b0, a_ir}, {31'b0, vq[i].eir});
         if (vq[i].chk_od)
            chk($sformatf("vec%0d_out_data", i), a_od, vq[i].eod);
      end
      a_rst = 1'b0; a_flush = 1'b0; a_iv = 1'b0; a_ordy = 1'b0;

      // ---------------- out-of-range select on instance B ----------------
      b_rst = 1'b1;
      @(posedge clk); #1;
      b_rst = 1'b0;
      chk("oor_reset_valid", {31'b0, b_ov}, 32'h0);
`ifdef MUX_SKID_SEL_ERR_EN
      chk("oor_reset_err", {31'b0, b_err}, 32'h0);
`endif
      b_iv = 1'b1; b_sel = 2'd3; b_ordy = 1'b1;
      @(posedge clk); #1;
      chk("oor_valid", {31'b0, b_ov}, 32'h1);
      chk("oor_zero_word", b_od, 32'h0);
`ifdef MUX_SKID_SEL_ERR_EN
      chk("oor_err_set", {31'b0, b_err}, 32'h1);
`endif
      b_sel = 2'd1;
      @(posedge clk); #1;
      chk("oor_inrange_word", b_od, 32'h2);
`ifdef MUX_SKID_SEL_ERR_EN
      chk("oor_err_sticky", {31'b0, b_err}, 32'h1);
`endif
      b_iv = 1'b0; b_flush = 1'b1;
      @(posedge clk); #1;
      b_flush = 1'b0;
      chk("oor_flush_valid", {31'b0, b_ov}, 32'h0);
`ifdef MUX_SKID_SEL_ERR_EN
      chk("oor_err_after_flush", {31'b0, b_err}, 32'h1);
`endif

      // ---------------- random traffic on instance C ----------------
      // Model: the stage is a FIFO of capacity two. out_valid means it is
      // non-empty and in_ready means it is not full. Flush and reset empty it.
      c_rst = 1'b1;
      @(posedge clk); #1;
      c_rst = 1'b0;
      mq.delete();
      last_acc = 1'b1;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (!c_iv || last_acc) begin
            c_iv  = ($urandom_range(0, 2) != 0);
            c_sel = 3'($urandom_range(0, 7));
            c_din = {$urandom, $urandom, $urandom, $urandom};
         end
         c_ordy  = ($urandom_range(0, 3) != 0);
         c_flush = ($urandom_range(0, 39) == 0);
         c_rst   = ($urandom_range(0, 999) == 0);
         word = c_din[int'(c_sel)*16 +: 16];
         acc  = c_iv && (mq.size() < 2);
         if (c_rst) begin
            mq.delete();
            last_acc = 1'b1;
         end else begin
            if (c_flush) begin
               mq.delete();
            end else begin
               if (mq.size() > 0 && c_ordy) void'(mq.pop_front());
               if (acc) mq.push_back(word);
            end
            last_acc = acc;
         end
         @(posedge clk); #1;
         chk($sformatf("rnd%0d_out_valid", cyc), {31'b0, c_ov}, {31'b0, (mq.size() > 0)});
         chk($sformatf("rnd%0d_in_ready", cyc), {31'b0, c_ir}, {31'b0, (mq.size() < 2)});
         if (mq.size() > 0)
            chk($sformatf("rnd%0d_out_data", cyc), {16'b0, c_od}, {16'b0, mq[0]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
